uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver. It is the receive end of the serial link driven by the UART transmitter in this system.
//  - Oversamples RX_IN at PRESCALE clocks per bit and resolves each bit by majority vote.
//  - Deserialises 2**data_width data bits, LSB first; checks optional parity and the stop bit.
//  - Presents the received word on P_DATA with a one-cycle data_valid strobe.
//  - Sits between the RX pad synchroniser and the system control / register-file logic.
// PARAMETERS
//  data_width  3  log2 of data bits per frame (3 -> 8-bit frames); same meaning as the transmitter's parameter
// PORTS
//  CLK         in   1               receiver oversampling clock
//  RST         in   1               asynchronous, active-high reset
//  RX_IN       in   1               serial input, idle high; already synchronised to CLK
//  PRESCALE    in   6               clocks per bit; legal values 8, 16, 32
//  PAR_EN      in   1               1 = frame carries a parity bit
//  PAR_TYP     in   1               0 = even parity, 1 = odd parity
//  P_DATA      out  2**data_width   last correctly received word
//  data_valid  out  1               1-cycle strobe: P_DATA updated with a clean frame
//  par_err     out  1               1-cycle strobe: parity mismatch in the frame just ended
//  stp_err     out  1               1-cycle strobe: stop bit sampled 0
//  busy        out  1               high while the FSM is not IDLE
// BEHAVIOUR
//  - Reset (asynchronous): FSM -> IDLE, all counters 0, P_DATA = 0, all strobes 0, busy = 0.
//    Reset mid-frame abandons the frame; no strobe is produced for it.
//  - Configuration latch: PRESCALE, PAR_EN and PAR_TYP are captured on start detection.
//    Changes during a frame have no effect on that frame.
//    PRESCALE values other than 8/16/32 are treated as 8.
//  - Timing reference: cycle 0 is the first IDLE cycle with RX_IN = 0. That cycle is edge_cnt = 0 of the start bit.
//  - edge_cnt counts 0..P-1 within each bit, then wraps to 0 and bit_cnt increments.
//  - Bit value: majority of the RX_IN samples at edge_cnt = P/2-1, P/2, P/2+1.
//    The value is used at edge_cnt = P-1.
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//    - IDLE -> START when RX_IN = 0.
//    - START, end of bit:
//      - voted 1 (glitch) -> IDLE; no strobes, P_DATA unchanged.
//      - voted 0 -> DATA.
//    - DATA: shifts the voted bit into bit (2**data_width - 1) each bit period, so the first bit lands in bit 0.
//      After the last data bit -> PARITY if PAR_EN = 1, else STOP.
//    - PARITY: expected parity = ^data (even) or ~^data (odd). Mismatch is recorded -> STOP.
//    - STOP, end of bit -> IDLE.
//      - On the next cycle (cycle N*P, where N = 2**data_width + 2 + PAR_EN) exactly one outcome occurs:
//        - data_valid = 1 and P_DATA loaded, only if parity is ok and stop = 1.
//        - otherwise par_err and/or stp_err pulse, and P_DATA holds its previous value.
//  - Back-to-back frames: a start bit that begins on the cycle right after the stop bit must be received.
//    IDLE detects it at most 1 cycle late, which is within the sampling margin.
//  - All outputs are registered. The strobes are never high for more than 1 consecutive cycle.
// STRUCTURE
//  - Shared package (uart_pkg): FSM state encoding; PRESCALE legal-value constants; parity-type constants.
//    The transmitter uses the same parity-type constants.
//  - Sub-module uart_rx_edge_bit_counter: edge_cnt/bit_cnt counters with end-of-bit flag.
//  - Top contains: FSM, 3-sample majority voter, shift register, parity/stop checkers, output registers.
// TESTING
//  1. P=8, PAR_EN=0, frame 0xA5 -> P_DATA=0xA5; data_valid high only at cycle 80; par_err = stp_err = 0.
//  2. P=16, even parity:
//     - 0x3C with parity 0 -> data_valid, P_DATA=0x3C.
//     - then 0x81 with parity 1 -> par_err pulse, no data_valid, P_DATA stays 0x3C.
//  3. P=8, 0x55 sent with stop bit 0 -> stp_err pulse at cycle 80; no data_valid; busy low at cycle 80.
//  4. P=16, RX_IN low for 3 cycles then high -> no strobes; busy falls after cycle 15.
//  5. P=32, odd parity, frames 0x00 and 0xFF back-to-back, one sample of each 3-sample vote flipped
//     -> both received; data_valid at cycles 352 and 704.
//  6. RST pulsed during data bit 4 -> outputs 0 immediately; the following frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, legal PRESCALE values and parity types.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam logic [5:0] PrescaleX8  = 6'd8;
  localparam logic [5:0] PrescaleX16 = 6'd16;
  localparam logic [5:0] PrescaleX32 = 6'd32;

  localparam logic ParEven = 1'b0;
  localparam logic ParOdd  = 1'b1;

  // Anything other than 16 or 32 clocks per bit falls back to 8.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    logic [5:0] r;
    unique case (p)
      PrescaleX16: r = PrescaleX16;
      PrescaleX32: r = PrescaleX32;
      default:     r = PrescaleX8;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling position tracker: edge_cnt within a bit, bit_cnt within a frame.
module uart_rx_edge_bit_counter #(
  parameter int unsigned CntW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            active,
  input  logic [5:0]      prescale,
  output logic [5:0]      edge_cnt,
  output logic [CntW-1:0] bit_cnt,
  output logic            bit_end
);

  logic [5:0]      edge_cnt_q, edge_cnt_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic            last_edge;

  assign last_edge = (edge_cnt_q == prescale - 6'd1);
  assign bit_end   = active && last_edge;
  assign edge_cnt  = edge_cnt_q;
  assign bit_cnt   = bit_cnt_q;

  // Next count: the start-detect cycle is edge 0, so the following cycle is edge 1.
  always_comb begin
    edge_cnt_d = 6'd0;
    bit_cnt_d  = '0;
    if (start) begin
      edge_cnt_d = 6'd1;
    end else if (active) begin
      if (last_edge) begin
        bit_cnt_d = bit_cnt_q + CntW'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + 6'd1;
        bit_cnt_d  = bit_cnt_q;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt_q <= 6'd0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: majority-voted oversampling, LSB-first deserialiser, parity and stop checks.
module uart_rx #(
  parameter int unsigned data_width = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_IN,
  input  logic [5:0]               PRESCALE,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  output logic [2**data_width-1:0] P_DATA,
  output logic                     data_valid,
  output logic                     par_err,
  output logic                     stp_err,
  output logic                     busy
);

  import uart_pkg::*;

  localparam int unsigned NumBits = 2 ** data_width;
  localparam int unsigned CntW    = data_width + 2;
  // bit_cnt is 0 during the start bit, so the last data bit is bit_cnt == NumBits.
  localparam logic [CntW-1:0] LastDataBit = CntW'(NumBits);

  rx_state_e state_q, state_d;

  logic [5:0]         prescale_q;
  logic               par_en_q, par_typ_q;
  logic [5:0]         edge_cnt;
  logic [CntW-1:0]    bit_cnt;
  logic               bit_end;
  logic               start, active;
  logic [5:0]         half;
  logic [2:0]         samp_q;
  logic               voted;
  logic               exp_par;

  logic [NumBits-1:0] shift_q, shift_d;
  logic [NumBits-1:0] p_data_q, p_data_d;
  logic               par_bad_q, par_bad_d;
  logic               data_valid_q, data_valid_d;
  logic               par_err_q, par_err_d;
  logic               stp_err_q, stp_err_d;
  logic               busy_q, busy_d;

  assign start  = (state_q == StIdle) && !RX_IN;
  assign active = (state_q != StIdle);
  assign half   = {1'b0, prescale_q[5:1]};
  assign voted  = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign exp_par = (par_typ_q == ParOdd) ? ~^shift_q : ^shift_q;

  uart_rx_edge_bit_counter #(
    .CntW(CntW)
  ) u_counter (
    .clk     (CLK),
    .rst     (RST),
    .start   (start),
    .active  (active),
    .prescale(prescale_q),
    .edge_cnt(edge_cnt),
    .bit_cnt (bit_cnt),
    .bit_end (bit_end)
  );

  // Frame configuration is frozen at start detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescale_q <= PrescaleX8;
      par_en_q   <= 1'b0;
      par_typ_q  <= ParEven;
    end else if (start) begin
      prescale_q <= legal_prescale(PRESCALE);
      par_en_q   <= PAR_EN;
      par_typ_q  <= PAR_TYP;
    end
  end

  // Capture the three mid-bit samples that feed the majority vote.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      samp_q <= 3'b000;
    end else if (active) begin
      if (edge_cnt == half - 6'd1) samp_q[0] <= RX_IN;
      if (edge_cnt == half)        samp_q[1] <= RX_IN;
      if (edge_cnt == half + 6'd1) samp_q[2] <= RX_IN;
    end
  end

  // Next-state, datapath and strobe decode; everything acts at the end of a bit.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!RX_IN) begin
          state_d   = StStart;
          par_bad_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) state_d = voted ? StIdle : StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d = {voted, shift_q[NumBits-1:1]};
          if (bit_cnt == LastDataBit) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (bit_end) begin
          par_bad_d = (voted != exp_par);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d = StIdle;
          if (!par_bad_q && voted) begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end else begin
            par_err_d = par_bad_q;
            stp_err_d = !voted;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-built frames, outputs checked at the cycle they must appear.
module tb_uart_rx;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  int dbl_cnt = 0;
  logic dv_prev = 1'b0;
  logic pe_prev = 1'b0;
  logic se_prev = 1'b0;

  int base_dv, base_pe, base_se;

  uart_rx #(
    .data_width(3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PRESCALE  (PRESCALE),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err),
    .busy      (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe monitor: pulse counts and any strobe held two cycles in a row.
  always @(negedge CLK) begin
    if (data_valid) dv_cnt <= dv_cnt + 1;
    if (par_err)    pe_cnt <= pe_cnt + 1;
    if (stp_err)    se_cnt <= se_cnt + 1;
    if ((data_valid && dv_prev) || (par_err && pe_prev) || (stp_err && se_prev))
      dbl_cnt <= dbl_cnt + 1;
    dv_prev <= data_valid;
    pe_prev <= par_err;
    se_prev <= stp_err;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold one bit for n cycles; the cycle at offset flip_e carries the inverted value.
  task automatic send_bit(input logic v, input int n, input int flip_e);
    for (int e = 0; e < n; e++) begin
      RX_IN = (e == flip_e) ? ~v : v;
      @(posedge CLK);
      #1;
    end
  endtask

  // Returns #1 after the edge that starts cycle N*P of the frame.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen, input logic pbit,
                            input logic stop, input logic flip);
    send_bit(1'b0, p, flip ? p / 2 - 1 : -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], p, flip ? p / 2 - 1 + (i % 3) : -1);
    if (pen) send_bit(pbit, p, flip ? p / 2 : -1);
    send_bit(stop, p, flip ? p / 2 + 1 : -1);
    RX_IN = 1'b1;
  endtask

  task automatic snap();
    base_dv = dv_cnt;
    base_pe = pe_cnt;
    base_se = se_cnt;
  endtask

  initial begin
    RST = 1'b1;
    RX_IN = 1'b1;
    PRESCALE = 6'd8;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_dv", 32'(data_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'({par_err, stp_err}), 32'd0);
    RST = 1'b0;
    repeat (4) @(posedge CLK);
    #1;

    // 1: P=8, no parity, 0xA5
    snap();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_dv_at_80", 32'(data_valid), 32'd1);
    chk("t1_pdata", 32'(P_DATA), 32'hA5);
    chk("t1_errs", 32'({par_err, stp_err}), 32'd0);
    @(posedge CLK);
    #1;
    chk("t1_dv_drop", 32'(data_valid), 32'd0);
    chk("t1_dv_count", 32'(dv_cnt - base_dv), 32'd1);
    chk("t1_err_count", 32'(pe_cnt - base_pe + se_cnt - base_se), 32'd0);

    // 2: P=16, even parity; good then bad parity
    PRESCALE = 6'd16;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    snap();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t2a_dv", 32'(data_valid), 32'd1);
    chk("t2a_pdata", 32'(P_DATA), 32'h3C);
    send_frame(8'h81, 16, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2b_par_err", 32'(par_err), 32'd1);
    chk("t2b_dv", 32'(data_valid), 32'd0);
    chk("t2b_stp_err", 32'(stp_err), 32'd0);
    chk("t2b_pdata_hold", 32'(P_DATA), 32'h3C);
    @(posedge CLK);
    #1;
    chk("t2_dv_count", 32'(dv_cnt - base_dv), 32'd1);
    chk("t2_pe_count", 32'(pe_cnt - base_pe), 32'd1);

    // 3: P=8, stop bit 0
    PRESCALE = 6'd8;
    PAR_EN = 1'b0;
    snap();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_stp_err", 32'(stp_err), 32'd1);
    chk("t3_dv", 32'(data_valid), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_pdata_hold", 32'(P_DATA), 32'h3C);
    @(posedge CLK);
    #1;
    chk("t3_se_count", 32'(se_cnt - base_se), 32'd1);

    // 4: P=16, 3-cycle glitch
    PRESCALE = 6'd16;
    repeat (3) @(posedge CLK);
    #1;
    snap();
    send_bit(1'b0, 3, -1);
    RX_IN = 1'b1;
    repeat (12) @(posedge CLK);
    #1;
    chk("t4_busy_c15", 32'(busy), 32'd1);
    @(posedge CLK);
    #1;
    chk("t4_busy_c16", 32'(busy), 32'd0);
    repeat (20) @(posedge CLK);
    #1;
    chk("t4_no_strobes", 32'(dv_cnt - base_dv + pe_cnt - base_pe + se_cnt - base_se), 32'd0);
    chk("t4_pdata_hold", 32'(P_DATA), 32'h3C);

    // 5: P=32, odd parity, back-to-back with one flipped sample per vote
    PRESCALE = 6'd32;
    PAR_EN = 1'b1;
    PAR_TYP = 1'b1;
    snap();
    send_frame(8'h00, 32, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5a_dv_352", 32'(data_valid), 32'd1);
    chk("t5a_pdata", 32'(P_DATA), 32'h00);
    send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5b_dv_704", 32'(data_valid), 32'd1);
    chk("t5b_pdata", 32'(P_DATA), 32'hFF);
    chk("t5b_par_err", 32'(par_err), 32'd0);
    @(posedge CLK);
    #1;
    chk("t5_dv_count", 32'(dv_cnt - base_dv), 32'd2);

    // 6: reset during data bit 4, then a clean frame with an illegal PRESCALE (acts as 8)
    PRESCALE = 6'd8;
    PAR_EN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    send_bit(1'b0, 8, -1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 8, -1);
    send_bit(1'b0, 3, -1);
    chk("t6_busy_pre", 32'(busy), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("t6_rst_pdata", 32'(P_DATA), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_dv", 32'(data_valid), 32'd0);
    repeat (2) @(posedge CLK);
    RX_IN = 1'b1;
    #1;
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    PRESCALE = 6'd12;
    snap();
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t6_dv", 32'(data_valid), 32'd1);
    chk("t6_pdata", 32'(P_DATA), 32'h5A);
    @(posedge CLK);
    #1;
    chk("t6_dv_count", 32'(dv_cnt - base_dv), 32'd1);

    chk("total_dv", 32'(dv_cnt), 32'd5);
    chk("total_pe", 32'(pe_cnt), 32'd1);
    chk("total_se", 32'(se_cnt), 32'd1);
    chk("strobe_width", 32'(dbl_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
